// File: rtl/car_park_pkg.sv
// Shared definitions for the car-park occupancy controller:
// the passage FSM state encoding and the default sizing.
package car_park_pkg;

    localparam int          W_DEFAULT        = 8;
    localparam int unsigned CAPACITY_DEFAULT = 200;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN1      = 3'd1,
        EN2      = 3'd2,
        EN3      = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        WAIT_CLR = 3'd7
    } state_e;

endpackage

// File: rtl/car_park_if.sv
// Gate-sensor and status bundle between the sensor/display side (master)
// and the car-park controller (slave).
interface car_park_if #(
    parameter int W = 8
);

    logic         a;
    logic         b;
    logic         enter;
    logic         exit;
    logic         seq_err;
    logic [W-1:0] count;
    logic         full;
    logic         empty;

    modport master (
        output a, b,
        input  enter, exit, seq_err, count, full, empty
    );

    modport slave (
        input  a, b,
        output enter, exit, seq_err, count, full, empty
    );

endinterface

// File: rtl/car_park_occupancy_counter.sv
// Saturating up/down occupancy counter: holds at 0 and at CAPACITY, never wraps.
module occupancy_counter #(
    parameter int          W        = 8,
    parameter int unsigned CAPACITY = 200
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] val
);

    localparam logic [W-1:0] CAP_C  = W'(CAPACITY);
    localparam logic [W-1:0] ZERO_C = W'(0);
    localparam logic [W-1:0] ONE_C  = W'(1);

    logic [W-1:0] val_r;

    // Occupancy register; inc and dec are mutually exclusive pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_r <= ZERO_C;
        end else if (inc && (val_r != CAP_C)) begin
            val_r <= val_r + ONE_C;
        end else if (dec && (val_r != ZERO_C)) begin
            val_r <= val_r - ONE_C;
        end else begin
            val_r <= val_r;
        end
    end

    assign val = val_r;

endmodule

// File: rtl/car_park_ctrl.sv
// Car-park gate controller: synchronises the two beam sensors, decodes full
// passages into enter/exit/seq_err pulses and drives the occupancy counter.
module car_park_ctrl
    import car_park_pkg::*;
#(
    parameter int          W        = W_DEFAULT,
    parameter int unsigned CAPACITY = CAPACITY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    car_park_if.slave   bus
);

    localparam logic [W-1:0] CAP_C  = W'(CAPACITY);
    localparam logic [W-1:0] ZERO_C = W'(0);

    logic [1:0]   a_sync_r;
    logic [1:0]   b_sync_r;
    logic [1:0]   ab_s;
    state_e       state_r;
    logic         enter_r;
    logic         exit_r;
    logic         seq_err_r;
    logic [W-1:0] count_s;

    // Two-flop synchronisers for the asynchronous sensor inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sync_r <= 2'b00;
            b_sync_r <= 2'b00;
        end else begin
            a_sync_r <= {a_sync_r[0], bus.a};
            b_sync_r <= {b_sync_r[0], bus.b};
        end
    end

    assign ab_s = {a_sync_r[1], b_sync_r[1]};

    // Passage FSM with registered event pulses; an unchanged ab holds the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            enter_r   <= 1'b0;
            exit_r    <= 1'b0;
            seq_err_r <= 1'b0;
        end else begin
            enter_r   <= 1'b0;
            exit_r    <= 1'b0;
            seq_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    case (ab_s)
                        2'b10:   state_r <= EN1;
                        2'b01:   state_r <= EX1;
                        2'b11:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= IDLE;
                    endcase
                end
                EN1: begin
                    case (ab_s)
                        2'b11:   state_r <= EN2;
                        2'b00:   state_r <= IDLE;
                        2'b01:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= EN1;
                    endcase
                end
                EN2: begin
                    case (ab_s)
                        2'b01:   state_r <= EN3;
                        2'b10:   state_r <= EN1;
                        2'b00:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= EN2;
                    endcase
                end
                EN3: begin
                    case (ab_s)
                        2'b00:   begin state_r <= IDLE; enter_r <= 1'b1; end
                        2'b11:   state_r <= EN2;
                        2'b10:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= EN3;
                    endcase
                end
                EX1: begin
                    case (ab_s)
                        2'b11:   state_r <= EX2;
                        2'b00:   state_r <= IDLE;
                        2'b10:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= EX1;
                    endcase
                end
                EX2: begin
                    case (ab_s)
                        2'b10:   state_r <= EX3;
                        2'b01:   state_r <= EX1;
                        2'b00:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= EX2;
                    endcase
                end
                EX3: begin
                    case (ab_s)
                        2'b00:   begin state_r <= IDLE; exit_r <= 1'b1; end
                        2'b11:   state_r <= EX2;
                        2'b01:   begin state_r <= WAIT_CLR; seq_err_r <= 1'b1; end
                        default: state_r <= EX3;
                    endcase
                end
                WAIT_CLR: begin
                    if (ab_s == 2'b00) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_CLR;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    occupancy_counter #(
        .W        (W),
        .CAPACITY (CAPACITY)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (enter_r),
        .dec     (exit_r),
        .val     (count_s)
    );

    assign bus.enter   = enter_r;
    assign bus.exit    = exit_r;
    assign bus.seq_err = seq_err_r;
    assign bus.count   = count_s;
    assign bus.full    = (count_s == CAP_C);
    assign bus.empty   = (count_s == ZERO_C);

endmodule
